// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetcher and the memory controller.
// A hit answers in one cycle; a miss fills a whole aligned block first.
module icache #(
    parameter int BLOCK_WIDTH = 1,
    parameter int CACHE_WIDTH = 8,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                          Sys_clk,
    input  logic                          Sys_rst_n,
    input  logic                          Sys_rdy,
    input  logic                          IFIC_en,
    input  logic [ADDR_WIDTH-1:0]         IFIC_addr,
    input  logic                          IFIC_clear,
    output logic                          ICIF_en,
    output logic [31:0]                   ICIF_inst,
    output logic                          ICMC_en,
    output logic [ADDR_WIDTH-1:0]         ICMC_addr,
    input  logic                          MCIC_en,
    input  logic [(32<<BLOCK_WIDTH)-1:0]  MCIC_block
);

    localparam int OFF_W  = BLOCK_WIDTH + 2;
    localparam int IDX_LO = OFF_W;
    localparam int IDX_HI = OFF_W + CACHE_WIDTH - 1;
    localparam int TAG_LO = OFF_W + CACHE_WIDTH;
    localparam int TAG_W  = ADDR_WIDTH - TAG_LO;
    localparam int LINES  = 1 << CACHE_WIDTH;
    localparam int BLK_W  = 32 << BLOCK_WIDTH;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MISS = 1'b1;

    logic [0:0]             r_state;
    logic                   r_abort;
    logic [ADDR_WIDTH-1:2]  r_miss_addr;
    logic [LINES-1:0]       r_valid;
    logic [TAG_W-1:0]       r_tag  [LINES];
    logic [BLK_W-1:0]       r_data [LINES];

    logic [CACHE_WIDTH-1:0] w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic [BLOCK_WIDTH-1:0] w_sel;
    logic [CACHE_WIDTH-1:0] w_midx;
    logic [TAG_W-1:0]       w_mtag;
    logic [BLOCK_WIDTH-1:0] w_msel;
    logic [BLK_W-1:0]       w_line;
    logic                   w_hit;
    logic                   w_req;
    logic                   w_fill;
    logic                   w_unused;

    assign w_idx  = IFIC_addr[IDX_HI:IDX_LO];
    assign w_tag  = IFIC_addr[ADDR_WIDTH-1:TAG_LO];
    assign w_sel  = IFIC_addr[OFF_W-1:2];
    assign w_midx = r_miss_addr[IDX_HI:IDX_LO];
    assign w_mtag = r_miss_addr[ADDR_WIDTH-1:TAG_LO];
    assign w_msel = r_miss_addr[OFF_W-1:2];
    assign w_line = r_data[w_idx];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_req  = IFIC_en && !IFIC_clear;
    assign w_fill = Sys_rdy && (r_state == S_MISS) && MCIC_en;

    assign w_unused = &{1'b0, IFIC_addr[1:0]};

    // Request drops in the done cycle so the controller never starts twice.
    assign ICMC_en   = (r_state == S_MISS) && !MCIC_en;
    assign ICMC_addr = {r_miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst_n && w_fill) begin
            r_tag[w_midx]  <= w_mtag;
            r_data[w_midx] <= MCIC_block;
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (!Sys_rst_n) begin
            r_state     <= S_IDLE;
            r_abort     <= 1'b0;
            r_miss_addr <= '0;
            r_valid     <= '0;
            ICIF_en     <= 1'b0;
            ICIF_inst   <= '0;
        end else if (Sys_rdy) begin
            ICIF_en <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            ICIF_en   <= 1'b1;
                            ICIF_inst <= w_line[{w_sel, 5'b0} +: 32];
                        end else begin
                            r_miss_addr <= IFIC_addr[ADDR_WIDTH-1:2];
                            r_abort     <= 1'b0;
                            r_state     <= S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (IFIC_clear) begin
                        r_abort <= 1'b1;
                    end
                    // An aborted fill still lands so the line is usable later.
                    if (MCIC_en) begin
                        r_valid[w_midx] <= 1'b1;
                        if (!r_abort && !IFIC_clear) begin
                            ICIF_en   <= 1'b1;
                            ICIF_inst <= MCIC_block[{w_msel, 5'b0} +: 32];
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: a fetch/fill scoreboard model checked every cycle,
// plus directed vectors with literal expectations.
module tb_icache;

    logic        Sys_clk;
    logic        Sys_rst_n;
    logic        Sys_rdy;
    logic        IFIC_en;
    logic [31:0] IFIC_addr;
    logic        IFIC_clear;
    logic        ICIF_en;
    logic [31:0] ICIF_inst;
    logic        ICMC_en;
    logic [31:0] ICMC_addr;
    logic        MCIC_en;
    logic [63:0] MCIC_block;

    icache dut (
        .Sys_clk    (Sys_clk),
        .Sys_rst_n  (Sys_rst_n),
        .Sys_rdy    (Sys_rdy),
        .IFIC_en    (IFIC_en),
        .IFIC_addr  (IFIC_addr),
        .IFIC_clear (IFIC_clear),
        .ICIF_en    (ICIF_en),
        .ICIF_inst  (ICIF_inst),
        .ICMC_en    (ICMC_en),
        .ICMC_addr  (ICMC_addr),
        .MCIC_en    (MCIC_en),
        .MCIC_block (MCIC_block)
    );

    initial Sys_clk = 1'b0;
    always #5 Sys_clk = ~Sys_clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit run    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    // Backing memory contents seen by the cache.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:3] == 29'd0) return a[2] ? 32'h11111111 : 32'h22222222;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // Model: which block each line holds, and at most one outstanding miss.
    bit          m_valid [256];
    int unsigned m_blk   [256];
    bit          exp_en;
    logic [31:0] exp_inst;
    bit          pend;
    bit          cancel;
    logic [31:0] paddr;

    always @(posedge Sys_clk) begin
        if (!Sys_rst_n) begin
            exp_en   = 0;
            exp_inst = 0;
            pend     = 0;
            cancel   = 0;
            for (int i = 0; i < 256; i++) m_valid[i] = 0;
        end else if (Sys_rdy) begin
            exp_en = 0;
            if (!pend) begin
                if (IFIC_en && !IFIC_clear) begin
                    int li;
                    li = int'(IFIC_addr[10:3]);
                    if (m_valid[li] && m_blk[li] == IFIC_addr[31:3]) begin
                        exp_en   = 1;
                        exp_inst = mem_word(IFIC_addr);
                    end else begin
                        pend   = 1;
                        cancel = 0;
                        paddr  = IFIC_addr;
                    end
                end
            end else begin
                if (IFIC_clear) cancel = 1;
                if (MCIC_en) begin
                    m_valid[int'(paddr[10:3])] = 1;
                    m_blk[int'(paddr[10:3])]   = paddr[31:3];
                    if (!cancel) begin
                        exp_en   = 1;
                        exp_inst = mem_word(paddr);
                    end
                    pend = 0;
                end
            end
        end
    end

    always @(negedge Sys_clk) begin
        if (run) begin
            chk("icif_en", {31'd0, ICIF_en}, {31'd0, exp_en});
            if (exp_en) chk("icif_inst", ICIF_inst, exp_inst);
            chk("icmc_en", {31'd0, ICMC_en}, {31'd0, pend && !MCIC_en});
            if (pend) chk("icmc_addr", ICMC_addr, {paddr[31:3], 3'b000});
        end
    end

    task automatic tick;
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        IFIC_en   = 1;
        IFIC_addr = a;
        tick();
        IFIC_en   = 0;
    endtask

    // Miss + controller: returns in the cycle after the done pulse.
    task automatic do_miss(input logic [31:0] a, input int lat,
                           input int clr_at);
        logic [31:0] blk;
        blk = {a[31:3], 3'b000};
        fetch(a);
        chk("miss_req", {31'd0, ICMC_en}, 32'd1);
        chk("miss_addr", ICMC_addr, blk);
        for (int i = 0; i < lat; i++) begin
            if (i == clr_at) IFIC_clear = 1;
            tick();
            IFIC_clear = 0;
        end
        MCIC_en    = 1;
        MCIC_block = {mem_word(blk | 32'd4), mem_word(blk)};
        #1;
        chk("req_drop", {31'd0, ICMC_en}, 32'd0);
        tick();
        MCIC_en = 0;
    endtask

    initial begin
        Sys_rst_n  = 0;
        Sys_rdy    = 1;
        IFIC_en    = 0;
        IFIC_addr  = 0;
        IFIC_clear = 0;
        MCIC_en    = 0;
        MCIC_block = 0;
        tick();
        run = 1;
        tick();
        Sys_rst_n = 1;
        chk("rst_icif_en", {31'd0, ICIF_en}, 32'd0);
        chk("rst_inst", ICIF_inst, 32'd0);
        chk("rst_icmc_en", {31'd0, ICMC_en}, 32'd0);
        chk("rst_icmc_addr", ICMC_addr, 32'd0);
        tick();

        do_miss(32'h4, 9, -1);
        chk("cold_en", {31'd0, ICIF_en}, 32'd1);
        chk("cold_inst", ICIF_inst, 32'h11111111);
        tick();
        chk("cold_pulse", {31'd0, ICIF_en}, 32'd0);

        IFIC_en   = 1;
        IFIC_addr = 32'h0;
        tick();
        chk("hit0_en", {31'd0, ICIF_en}, 32'd1);
        chk("hit0_inst", ICIF_inst, 32'h22222222);
        IFIC_addr = 32'h4;
        tick();
        IFIC_en = 0;
        chk("hit4_en", {31'd0, ICIF_en}, 32'd1);
        chk("hit4_inst", ICIF_inst, 32'h11111111);
        chk("hit_no_req", {31'd0, ICMC_en}, 32'd0);
        tick();

        do_miss(32'h800, 9, -1);
        chk("conf_inst", ICIF_inst, mem_word(32'h800));
        do_miss(32'h0, 10, -1);
        chk("refill_inst", ICIF_inst, 32'h22222222);
        tick();

        do_miss(32'h1000, 12, 2);
        chk("abort_no_resp", {31'd0, ICIF_en}, 32'd0);
        tick();
        fetch(32'h1000);
        chk("post_abort_hit", {31'd0, ICIF_en}, 32'd1);
        chk("post_abort_inst", ICIF_inst, mem_word(32'h1000));

        IFIC_clear = 1;
        fetch(32'h0);
        chk("drop_hit", {31'd0, ICIF_en}, 32'd0);
        fetch(32'h3000);
        IFIC_clear = 0;
        chk("drop_miss", {31'd0, ICMC_en}, 32'd0);
        tick();

        IFIC_en   = 1;
        IFIC_addr = 32'h1004;
        Sys_rdy   = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_quiet", {31'd0, ICIF_en}, 32'd0);
        end
        Sys_rdy = 1;
        tick();
        IFIC_en = 0;
        chk("stall_en", {31'd0, ICIF_en}, 32'd1);
        chk("stall_inst", ICIF_inst, mem_word(32'h1004));
        tick();
        chk("stall_pulse", {31'd0, ICIF_en}, 32'd0);

        fetch(32'h2008);
        tick();
        tick();
        chk("mid_miss", {31'd0, ICMC_en}, 32'd1);
        Sys_rst_n = 0;
        tick();
        Sys_rst_n = 1;
        chk("rst_mm_icmc", {31'd0, ICMC_en}, 32'd0);
        chk("rst_mm_icif", {31'd0, ICIF_en}, 32'd0);
        MCIC_en    = 1;
        MCIC_block = {mem_word(32'h200C), mem_word(32'h2008)};
        tick();
        MCIC_en = 0;
        chk("stray_fill", {31'd0, ICIF_en}, 32'd0);
        tick();
        do_miss(32'h2008, 9, -1);
        chk("remiss_inst", ICIF_inst, mem_word(32'h2008));
        tick();
        fetch(32'h200C);
        chk("remiss_hit", ICIF_inst, mem_word(32'h200C));
        tick();
        tick();

        run = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
